// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: greedy largest-first denomination selection (50/20/10/5/1),
// one hopper item per valid/ready handshake, with abort, stall timeout and fault lockout.
module change_dispense_ctrl #(
  parameter int MONEY_W     = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [MONEY_W-1:0] change_in,
  input  logic               abort,
  output logic               dispense_valid,
  output logic [2:0]         dispense_denom,
  input  logic               dispense_ready,
  output logic [MONEY_W-1:0] remaining,
  output logic [3:0]         coin_count,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic               abort_lat, abort_lat_nxt;
  logic [MONEY_W-1:0] remaining_nxt;
  logic [3:0]         coin_count_nxt;
  logic [2:0]         denom_nxt;

  // Largest denomination code whose value does not exceed amt (amt > 0).
  function automatic logic [2:0] pick_denom(input logic [MONEY_W-1:0] amt);
    if (amt >= MONEY_W'(50))      return 3'd4;
    else if (amt >= MONEY_W'(20)) return 3'd3;
    else if (amt >= MONEY_W'(10)) return 3'd2;
    else if (amt >= MONEY_W'(5))  return 3'd1;
    else                          return 3'd0;
  endfunction

  function automatic logic [MONEY_W-1:0] denom_value(input logic [2:0] code);
    case (code)
      3'd4:    return MONEY_W'(50);
      3'd3:    return MONEY_W'(20);
      3'd2:    return MONEY_W'(10);
      3'd1:    return MONEY_W'(5);
      default: return MONEY_W'(1);
    endcase
  endfunction

  // Item counter saturates instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_nxt      = state;
    tmo_cnt_nxt    = tmo_cnt;
    abort_lat_nxt  = abort_lat;
    remaining_nxt  = remaining;
    coin_count_nxt = coin_count;
    denom_nxt      = dispense_denom;

    case (state)
      S_IDLE: begin
        if (start) begin
          remaining_nxt  = change_in;
          coin_count_nxt = 4'd0;
          abort_lat_nxt  = 1'b0;
          state_nxt      = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining == '0 || abort || abort_lat) begin
          state_nxt = S_DONE;
        end else begin
          denom_nxt   = pick_denom(remaining);
          tmo_cnt_nxt = '0;
          state_nxt   = S_ISSUE;
        end
      end

      // The request stays up until its handshake; an abort here only prevents the next one.
      S_ISSUE: begin
        if (abort) abort_lat_nxt = 1'b1;
        if (dispense_ready) begin
          remaining_nxt  = remaining - denom_value(dispense_denom);
          coin_count_nxt = sat_inc4(coin_count);
          state_nxt      = S_SELECT;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
          if (tmo_cnt_nxt == TMO_W'(TIMEOUT_CYC)) state_nxt = S_FAULT;
        end
      end

      S_DONE: begin
        abort_lat_nxt = 1'b0;
        state_nxt     = S_IDLE;
      end

      S_FAULT: begin
        state_nxt = S_FAULT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      tmo_cnt        <= '0;
      abort_lat      <= 1'b0;
      remaining      <= '0;
      coin_count     <= 4'd0;
      dispense_denom <= 3'd0;
    end else begin
      state          <= state_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
      abort_lat      <= abort_lat_nxt;
      remaining      <= remaining_nxt;
      coin_count     <= coin_count_nxt;
      dispense_denom <= denom_nxt;
    end
  end

  assign dispense_valid = (state == S_ISSUE);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign error          = (state == S_FAULT);

endmodule
